// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state type and sign helpers for the shift-add multiplier
package mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

  localparam int DEFAULT_WIDTH = 8;

  // Callers sign-extend into 32 bits first; the magnitude of the most negative
  // narrow value still fits once truncated back to the operand width.
  function automatic logic [31:0] magnitude(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] negate(input logic [63:0] v);
    return ~v + 64'd1;
  endfunction

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - multi-cycle shift-add multiplier, signed/unsigned per operation
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] C
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = 2 * WIDTH;

  mult_state_t    state;
  logic [CW-1:0]  cnt;
  logic [WIDTH-1:0] mcand;
  logic [PW-1:0]  acc;
  logic           sign;

  logic [WIDTH:0] psum;
  logic [PW-1:0]  acc_next;

  // acc holds the running high half above the not-yet-consumed multiplier bits;
  // the adder carry lands in the top bit as everything shifts right by one.
  always_comb begin
    psum     = {1'b0, acc[PW-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
    acc_next = {psum, acc[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      mcand <= '0;
      acc   <= '0;
      sign  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      C     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand <= signed_mode ? WIDTH'(magnitude(32'($signed(A)))) : A;
            acc   <= {{WIDTH{1'b0}},
                      signed_mode ? WIDTH'(magnitude(32'($signed(B)))) : B};
            sign  <= signed_mode & (A[WIDTH-1] ^ B[WIDTH-1]);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
            done  <= 1'b1;
            C     <= sign ? PW'(negate(64'(acc_next))) : acc_next;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          cnt   <= '0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// tb/tb_seq_multiplier.sv - self-checking bench for seq_multiplier against an arithmetic reference
module tb_seq_multiplier;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic           signed_mode;
  logic [W-1:0]   A;
  logic [W-1:0]   B;
  logic           busy;
  logic           done;
  logic [2*W-1:0] C;

  int errors = 0;
  int checks = 0;

  seq_multiplier #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .signed_mode(signed_mode),
    .A(A),
    .B(B),
    .busy(busy),
    .done(done),
    .C(C)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b, input logic sm);
    int sa;
    int sb;
    sa = sm ? {{24{a[7]}}, a} : {24'd0, a};
    sb = sm ? {{24{b[7]}}, b} : {24'd0, b};
    return 16'(sa * sb);
  endfunction

  // Starts one operation in the current cycle (cycle 0) and observes cycles 1..W+2.
  // Operand inputs are scrambled after the start cycle. Returns at cycle W+2.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                       output int done_cyc, output int done_cnt, output logic [15:0] c_done,
                       output int busy_bad, output logic c_stable);
    logic [15:0] prev_c;
    done_cyc = -1;
    done_cnt = 0;
    c_done   = 'x;
    busy_bad = 0;
    c_stable = 1'b1;
    prev_c   = C;
    A = a; B = b; signed_mode = sm; start = 1'b1;
    for (int cyc = 1; cyc <= W + 2; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      A = 8'($urandom); B = 8'($urandom); signed_mode = 1'($urandom);
      if (busy !== ((cyc >= 1) && (cyc <= W + 1))) busy_bad++;
      if (done === 1'b1) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc;
          c_done   = C;
        end
      end else if (C !== prev_c) begin
        c_stable = 1'b0;
      end
      prev_c = C;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; signed_mode = 1'b0; A = 8'd5; B = 8'd5;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || C !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b C=%h, expected busy=0 done=0 C=0000", busy, done, C);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_start_wins: busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_unsigned;
    logic [7:0] ta [3];
    logic [7:0] tb [3];
    logic [15:0] exp_c [3];
    int dc, dn, bb;
    logic [15:0] cd;
    logic cs;
    ta = '{8'd13, 8'd255, 8'd0};
    tb = '{8'd11, 8'd255, 8'd200};
    exp_c = '{16'h008F, 16'hFE01, 16'h0000};
    for (int i = 0; i < 3; i++) begin
      do_op(ta[i], tb[i], 1'b0, dc, dn, cd, bb, cs);
      checks++;
      if (cd !== exp_c[i] || ref_mul(ta[i], tb[i], 1'b0) !== exp_c[i]) begin
        errors++;
        $display("FAIL unsigned_%0d_product: C=%h, expected %h", i, cd, exp_c[i]);
      end
      checks++;
      if (dc !== W + 1 || dn !== 1) begin
        errors++;
        $display("FAIL unsigned_%0d_latency: done cycle=%0d count=%0d, expected cycle %0d count 1", i, dc, dn, W + 1);
      end
      checks++;
      if (bb !== 0 || cs !== 1'b1) begin
        errors++;
        $display("FAIL unsigned_%0d_busy_hold: busy errors=%0d C stable=%b, expected 0 and 1", i, bb, cs);
      end
    end
  endtask

  task automatic test_signed;
    logic [7:0] ta [4];
    logic [7:0] tb [4];
    logic sm [4];
    logic [15:0] exp_c [4];
    int dc, dn, bb;
    logic [15:0] cd;
    logic cs;
    ta = '{8'hFD, 8'h80, 8'h80, 8'h80};
    tb = '{8'h05, 8'h80, 8'h7F, 8'h80};
    sm = '{1'b1, 1'b1, 1'b1, 1'b0};
    exp_c = '{16'hFFF1, 16'h4000, 16'hC080, 16'h4000};
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], sm[i], dc, dn, cd, bb, cs);
      checks++;
      if (cd !== exp_c[i] || dc !== W + 1 || dn !== 1) begin
        errors++;
        $display("FAIL signed_%0d: C=%h cycle=%0d count=%0d, expected C=%h cycle %0d count 1",
                 i, cd, dc, dn, exp_c[i], W + 1);
      end
    end
  endtask

  task automatic test_start_held;
    int done_cycles [$];
    logic [15:0] c9, c19;
    c9 = 'x; c19 = 'x;
    A = 8'd21; B = 8'd3; signed_mode = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= 2 * W + 4; cyc++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        done_cycles.push_back(cyc);
        if (cyc == W + 1) c9 = C;
        if (cyc == 2 * W + 3) c19 = C;
      end
      if (cyc < W + 2) begin
        A = 8'($urandom); B = 8'($urandom); signed_mode = 1'($urandom);
      end else if (cyc == W + 2) begin
        A = 8'hF9; B = 8'd12; signed_mode = 1'b1;
      end else begin
        start = 1'b0;
        A = 8'($urandom); B = 8'($urandom);
      end
    end
    start = 1'b0;
    checks++;
    if (done_cycles.size() != 2 || done_cycles[0] != W + 1 || done_cycles[1] != 2 * W + 3) begin
      errors++;
      $display("FAIL start_held_done_cycles: count=%0d first=%0d, expected 2 pulses at %0d and %0d",
               done_cycles.size(), (done_cycles.size() > 0) ? done_cycles[0] : -1, W + 1, 2 * W + 3);
    end
    checks++;
    if (c9 !== ref_mul(8'd21, 8'd3, 1'b0)) begin
      errors++;
      $display("FAIL start_held_first_product: C=%h, expected %h", c9, ref_mul(8'd21, 8'd3, 1'b0));
    end
    checks++;
    if (c19 !== 16'hFFAC) begin
      errors++;
      $display("FAIL start_held_second_product: C=%h, expected ffac", c19);
    end
  endtask

  task automatic test_reset_mid_calc;
    int stray_done;
    int dc, dn, bb;
    logic [15:0] cd;
    logic cs;
    stray_done = 0;
    A = 8'd9; B = 8'd9; signed_mode = 1'b0; start = 1'b1;
    for (int cyc = 1; cyc <= W + 5; cyc++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (cyc == 4) reset = 1'b1;
      if (cyc == 5) begin
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || C !== 16'h0000) begin
          errors++;
          $display("FAIL reset_mid_calc_state: busy=%b done=%b C=%h, expected 0 0 0000", busy, done, C);
        end
      end
      if (cyc >= 5 && (done !== 1'b0 || C !== 16'h0000 || busy !== 1'b0)) stray_done++;
    end
    checks++;
    if (stray_done != 0) begin
      errors++;
      $display("FAIL reset_mid_calc_no_done: activity cycles=%0d, expected 0", stray_done);
    end
    do_op(8'd7, 8'd6, 1'b0, dc, dn, cd, bb, cs);
    checks++;
    if (cd !== 16'h002A || dc !== W + 1 || dn !== 1) begin
      errors++;
      $display("FAIL reset_mid_calc_fresh_op: C=%h cycle=%0d count=%0d, expected 002a at %0d", cd, dc, dn, W + 1);
    end
  endtask

  task automatic test_back_to_back;
    int dc, dn, bb;
    logic [15:0] cd;
    logic cs;
    logic [7:0] a, b;
    logic sm;
    int total_done, mism, accepted;
    total_done = 0; mism = 0; accepted = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); sm = 1'($urandom);
      if (i < 8) begin
        a = (i[0]) ? 8'h80 : 8'hFF;
        b = (i[1]) ? 8'h7F : 8'h80;
        sm = i[2];
      end
      do_op(a, b, sm, dc, dn, cd, bb, cs);
      accepted++;
      total_done += dn;
      checks++;
      if (cd !== ref_mul(a, b, sm) || dc !== W + 1 || bb !== 0 || cs !== 1'b1) begin
        errors++;
        mism++;
        if (mism <= 10)
          $display("FAIL random_op_%0d: a=%h b=%h sm=%b C=%h cycle=%0d busy_err=%0d, expected C=%h cycle %0d",
                   i, a, b, sm, cd, dc, bb, ref_mul(a, b, sm), W + 1);
      end
    end
    checks++;
    if (total_done != accepted) begin
      errors++;
      $display("FAIL random_done_count: dones=%0d, expected %0d", total_done, accepted);
    end
  endtask

  initial begin
    test_reset;
    test_unsigned;
    test_signed;
    test_start_held;
    test_reset_mid_calc;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
